// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port data memory.
// Optional grant/conflict statistics counters are enabled with `define DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_rsp_valid,
  output logic [DW-1:0] p0_rsp_rdata,
  output logic          p0_rsp_err,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_rsp_valid,
  output logic [DW-1:0] p1_rsp_rdata,
  output logic          p1_rsp_err,
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_WD,
  output logic          mem_WE,
  input  logic [DW-1:0] mem_RD
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   p0_grant_cnt,
  output logic [15:0]   p1_grant_cnt,
  output logic [15:0]   conflict_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_nxt;
  logic          last_grant;
  logic          gnt_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          any_valid;
  logic          arb_en;
  logic          grant;
  logic          pick;
  logic          aligned;

  assign any_valid = p0_valid | p1_valid;
  assign arb_en    = (state == IDLE) || (state == RESP);
  assign grant     = arb_en && any_valid;
  // Under contention the port that did not win last time gets the slot.
  assign pick      = (p0_valid && p1_valid) ? ~last_grant : p1_valid;
  assign aligned   = (addr_q[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = any_valid ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant   <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      p0_rsp_rdata <= '0;
      p1_rsp_rdata <= '0;
    end else begin
      if (grant) begin
        gnt_q      <= pick;
        last_grant <= pick;
        we_q       <= pick ? p1_we    : p0_we;
        addr_q     <= pick ? p1_addr  : p0_addr;
        wdata_q    <= pick ? p1_wdata : p0_wdata;
      end
      // Read data is captured at the end of ACCESS and then held until the next response.
      if (state == ACCESS) begin
        if (!gnt_q) p0_rsp_rdata <= (we_q || !aligned) ? '0 : mem_RD;
        else        p1_rsp_rdata <= (we_q || !aligned) ? '0 : mem_RD;
      end
    end
  end

  always_comb begin
    mem_A        = addr_q;
    mem_WD       = wdata_q;
    mem_WE       = (state == ACCESS) && we_q && aligned && !rst;
    p0_ready     = (state == ACCESS) && !gnt_q && !rst;
    p1_ready     = (state == ACCESS) &&  gnt_q && !rst;
    p0_rsp_valid = (state == RESP)   && !gnt_q && !rst;
    p1_rsp_valid = (state == RESP)   &&  gnt_q && !rst;
    p0_rsp_err   = p0_rsp_valid && !aligned;
    p1_rsp_err   = p1_rsp_valid && !aligned;
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_grant_cnt <= '0;
      p1_grant_cnt <= '0;
      conflict_cnt <= '0;
    end else if (grant) begin
      if (!pick && p0_grant_cnt != 16'hFFFF) p0_grant_cnt <= p0_grant_cnt + 16'd1;
      if ( pick && p1_grant_cnt != 16'hFFFF) p1_grant_cnt <= p1_grant_cnt + 16'd1;
      if (p0_valid && p1_valid && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests push expected grants/responses,
// a negedge monitor pops and compares them against the DUT.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p0_ready, p0_we, p0_rsp_valid, p0_rsp_err;
  logic [31:0] p0_addr, p0_wdata, p0_rsp_rdata;
  logic        p1_valid, p1_ready, p1_we, p1_rsp_valid, p1_rsp_err;
  logic [31:0] p1_addr, p1_wdata, p1_rsp_rdata;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_WE;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] p0_grant_cnt, p1_grant_cnt, conflict_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int we_cnt = 0;
  int rsp_cyc0 = 0, rsp_cyc1 = 0;
  logic prev_rdy0 = 1'b0, prev_rdy1 = 1'b0;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic        gq[$];

  logic [31:0] tb_mem [64];

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p0_rsp_err(p0_rsp_err),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .p1_rsp_err(p1_rsp_err),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
`ifdef DMEM_ARB_STATS_EN
    , .p0_grant_cnt(p0_grant_cnt), .p1_grant_cnt(p1_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  // Data memory model: synchronous write, combinational read
  initial for (int i = 0; i < 64; i++) tb_mem[i] = 32'h0;
  always @(posedge clk) if (mem_WE) tb_mem[mem_A[7:2]] <= mem_WD;
  assign mem_RD = tb_mem[mem_A[7:2]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    cyc++;
    if (mem_WE) we_cnt++;
    if (p0_ready || p1_ready) begin
      if (gq.size() == 0) chk("unexpected_grant", {p1_ready, p0_ready}, 2'b00);
      else chk("grant_id", {p0_ready, p1_ready}, gq[0] ? 2'b01 : 2'b10);
      if (gq.size() != 0) void'(gq.pop_front());
    end
    if (p0_rsp_valid) begin
      chk("p0_latency", prev_rdy0, 1'b1);
      if (q0.size() == 0) chk("p0_unexpected_rsp", 1'b1, 1'b0);
      else begin
        e = q0.pop_front();
        chk("p0_rdata", p0_rsp_rdata, e[31:0]);
        chk("p0_err", p0_rsp_err, e[32]);
      end
      rsp_cyc0 = cyc;
    end
    if (p1_rsp_valid) begin
      chk("p1_latency", prev_rdy1, 1'b1);
      if (q1.size() == 0) chk("p1_unexpected_rsp", 1'b1, 1'b0);
      else begin
        e = q1.pop_front();
        chk("p1_rdata", p1_rsp_rdata, e[31:0]);
        chk("p1_err", p1_rsp_err, e[32]);
      end
      rsp_cyc1 = cyc;
    end
    prev_rdy0 = p0_ready;
    prev_rdy1 = p1_ready;
  end

  // Requests are raised at posedge+1 and return at posedge+1 after the handshake edge.
  task automatic p0_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    int n = 0;
    p0_valid = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd;
    q0.push_back({exp_err, exp_rd});
    do begin @(negedge clk); n++; end while (!p0_ready && n < 20);
    if (!p0_ready) chk("p0_ready_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic p1_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    int n = 0;
    p1_valid = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd;
    q1.push_back({exp_err, exp_rd});
    do begin @(negedge clk); n++; end while (!p1_ready && n < 20);
    if (!p1_ready) chk("p1_ready_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
  endtask

  initial begin
    int snap;
    p0_valid = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_valid = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    @(posedge clk); #1;
    do_reset();

    @(negedge clk);
    chk("rst_mem_A", mem_A, 32'h0);
    chk("rst_mem_WD", mem_WD, 32'h0);
    chk("rst_mem_WE", mem_WE, 1'b0);
    chk("rst_ready", {p0_ready, p1_ready}, 2'b00);
    chk("rst_rsp_valid", {p0_rsp_valid, p1_rsp_valid}, 2'b00);
    chk("rst_rsp_err", {p0_rsp_err, p1_rsp_err}, 2'b00);
    chk("rst_rsp_rdata", {p0_rsp_rdata, p1_rsp_rdata}, 64'h0);
    @(posedge clk); #1;

    // Single write with explicit cycle-1 timing, then read back
    gq.push_back(1'b0);
    q0.push_back({1'b0, 32'h0});
    p0_valid = 1; p0_we = 1; p0_addr = 32'd20; p0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("c0_ready", p0_ready, 1'b0);
    chk("c0_mem_WE", mem_WE, 1'b0);
    @(negedge clk);
    chk("c1_ready", p0_ready, 1'b1);
    chk("c1_mem_WE", mem_WE, 1'b1);
    chk("c1_mem_A", mem_A, 32'd20);
    @(posedge clk); #1;
    p0_valid = 0;
    idle(2);
    gq.push_back(1'b0);
    p0_req(1'b0, 32'd20, 32'h0, 32'hDEADBEEF, 1'b0);
    p0_valid = 0;
    idle(2);

    // Contention from reset: port 0 wins first
    do_reset();
    gq.push_back(1'b0); gq.push_back(1'b1);
    fork
      begin p0_req(1'b1, 32'd32, 32'hCAFEBABE, 32'h0, 1'b0); p0_valid = 0; end
      begin p1_req(1'b0, 32'd32, 32'h0, 32'hCAFEBABE, 1'b0); p1_valid = 0; end
    join
    idle(2);
    chk("contention_rsp_spacing", rsp_cyc1 - rsp_cyc0, 2);

    // Fairness: both ports hold valid for 8 grants
    for (int i = 0; i < 4; i++) begin gq.push_back(1'b0); gq.push_back(1'b1); end
    fork
      begin
        for (int i = 0; i < 4; i++) p0_req(1'b0, 32'd32, 32'h0, 32'hCAFEBABE, 1'b0);
        p0_valid = 0;
      end
      begin
        for (int j = 0; j < 4; j++) p1_req(1'b0, 32'd20, 32'h0, 32'hDEADBEEF, 1'b0);
        p1_valid = 0;
      end
    join
    idle(2);

    // Misaligned write: no memory write, error response
    snap = we_cnt;
    gq.push_back(1'b1);
    p1_req(1'b1, 32'd22, 32'h12345678, 32'h0, 1'b1);
    p1_valid = 0;
    idle(2);
    chk("misaligned_no_we", we_cnt, snap);
    gq.push_back(1'b0);
    p0_req(1'b0, 32'd20, 32'h0, 32'hDEADBEEF, 1'b0);
    p0_valid = 0;
    idle(2);

    // Reset during ACCESS of a write
    gq.push_back(1'b0);
    p0_req(1'b1, 32'd40, 32'h11112222, 32'h0, 1'b0);
    p0_valid = 0;
    idle(2);
    snap = we_cnt;
    p0_valid = 1; p0_we = 1; p0_addr = 32'd40; p0_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_access_mem_WE", mem_WE, 1'b0);
    chk("rst_access_ready", p0_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; p0_valid = 0;
    @(negedge clk);
    chk("post_rst_idle", {p0_ready, p0_rsp_valid, mem_WE}, 3'b000);
    @(negedge clk);
    chk("post_rst_idle2", {p0_ready, p0_rsp_valid, mem_WE}, 3'b000);
    chk("rst_access_no_write", we_cnt, snap);
    @(posedge clk); #1;
    gq.push_back(1'b0);
    p0_req(1'b0, 32'd40, 32'h0, 32'h11112222, 1'b0);
    p0_valid = 0;
    idle(2);

`ifdef DMEM_ARB_STATS_EN
    do_reset();
    gq.push_back(1'b0);
    p0_req(1'b0, 32'd20, 32'h0, 32'hDEADBEEF, 1'b0); p0_valid = 0; idle(1);
    gq.push_back(1'b1);
    p1_req(1'b0, 32'd20, 32'h0, 32'hDEADBEEF, 1'b0); p1_valid = 0; idle(1);
    gq.push_back(1'b0); gq.push_back(1'b1);
    fork
      begin p0_req(1'b0, 32'd32, 32'h0, 32'hCAFEBABE, 1'b0); p0_valid = 0; end
      begin p1_req(1'b0, 32'd32, 32'h0, 32'hCAFEBABE, 1'b0); p1_valid = 0; end
    join
    idle(2);
    gq.push_back(1'b0);
    p0_req(1'b0, 32'd40, 32'h0, 32'h11112222, 1'b0); p0_valid = 0;
    idle(2);
    chk("stats_p0", p0_grant_cnt, 16'd3);
    chk("stats_p1", p1_grant_cnt, 16'd2);
    chk("stats_conflict", conflict_cnt, 16'd1);
    do_reset();
    chk("stats_rst", {p0_grant_cnt, p1_grant_cnt, conflict_cnt}, 48'h0);
`endif

    for (int k = 0; k < 20 && (q0.size() + q1.size() + gq.size()) != 0; k++) @(posedge clk);
    chk("p0_rsp_pending", q0.size(), 0);
    chk("p1_rsp_pending", q1.size(), 0);
    chk("grant_pending", gq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port Data_Memory (word-addressed by byte address, synchronous write on WE, combinational RD).
- Port 0 serves the core load/store unit; port 1 serves the debug/DMA loader.
- Each requester uses a valid/ready request channel and a one-cycle response pulse.
- The block owns the memory A/WD/WE pins exclusively, round-robins on contention and rejects misaligned accesses.

Parameters:
- AW, 32, address width (byte address)
- DW, 32, data width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- p0_valid  in  1  port 0 request valid
- p0_ready  out  1  port 0 request accepted this cycle
- p0_we  in  1  port 0 write (1) / read (0)
- p0_addr  in  AW  port 0 byte address
- p0_wdata  in  DW  port 0 write data
- p0_rsp_valid  out  1  port 0 response pulse
- p0_rsp_rdata  out  DW  port 0 read data (0 for writes)
- p0_rsp_err  out  1  port 0 misaligned-access error
- p1_*  same set as port 0, for port 1
- mem_A  out  AW  to Data_Memory A
- mem_WD  out  DW  to Data_Memory WD
- mem_WE  out  1  to Data_Memory WE
- mem_RD  in  DW  from Data_Memory RD

Behaviour:
- Reset: synchronous, active-high. State=IDLE, last_grant=1 (port 0 wins first contention).
- Reset values: all outputs 0, including mem_A, mem_WD, mem_WE, pX_ready, pX_rsp_*.
- FSM: IDLE, ACCESS, RESP.
- IDLE: if any pX_valid, pick a winner and latch its we/addr/wdata plus a grant-id register, then go to ACCESS. Otherwise stay.
- Winner selection: if only one port is valid, that port wins. If both are valid, the port != last_grant wins. last_grant updates on every grant.
- ACCESS (exactly one cycle):
  - mem_A = latched addr; mem_WD = latched wdata.
  - mem_WE = latched we AND (addr[1:0]==0) AND !rst.
  - pX_ready=1 for the granted port only. The request handshake completes at the end of this cycle.
  - mem_RD is captured at the end of the cycle into rdata_q.
  - Next state is RESP.
- RESP (one cycle):
  - Granted port: pX_rsp_valid=1.
  - pX_rsp_rdata = rdata_q for an aligned read, 0 otherwise.
  - pX_rsp_err = (addr[1:0]!=0).
  - If any valid is pending, arbitrate exactly as in IDLE and go directly to ACCESS (back-to-back). Otherwise go to IDLE.
- Latency: valid rising in cycle 0 gives ready in cycle 1 and rsp_valid in cycle 2. Sustained throughput is one access per 2 cycles.
- Requester rules: must hold valid/we/addr/wdata stable until ready. Dropping valid before ready is illegal, but the request is already latched, so the access still completes.
- Outside ACCESS: mem_WE=0; mem_A/mem_WD hold their last driven value.
- Outside RESP: rsp_valid/rsp_err=0; rsp_rdata holds its value.
- Misaligned access: no memory write, rsp_err=1, rdata=0. It still consumes a full ACCESS+RESP slot and counts as a grant for fairness.
- Reset asserted in ACCESS: mem_WE forced 0 that cycle, no response issued, FSM goes to IDLE.
- Reset asserted in RESP: the pulse is suppressed.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs p0_grant_cnt[15:0], p1_grant_cnt[15:0] and conflict_cnt[15:0].
  - pX_grant_cnt increments on each grant to port X.
  - conflict_cnt increments on each arbitration cycle with both valids asserted.
  - All counters saturate at 16'hFFFF and clear on rst.
- Undefined: no counters and no extra ports. Behaviour is otherwise identical.

Test Plan:
- Single write/read, port 0:
  - Write 32'hDEADBEEF to addr 20 -> mem_WE high for one cycle in cycle 1; p0_rsp_valid in cycle 2 with err=0.
  - Then read addr 20 -> p0_rsp_rdata=32'hDEADBEEF.
- Contention from reset:
  - Both ports valid in the same cycle, p0 write 32'hCAFEBABE@32, p1 read @32 -> p0 granted first, p1 granted in the following ACCESS.
  - p1 reads 32'hCAFEBABE; rsp pulses 2 cycles apart.
- Fairness: both ports hold valid continuously for 8 grants -> strict alternation 0,1,0,1…; neither port granted twice in a row.
- Misaligned access: p1 write @addr 22, data 32'h12345678 -> mem_WE never asserted, p1_rsp_err=1. A subsequent read @20 returns the prior value unchanged.
- Reset mid-access: assert rst during the ACCESS of a write 32'hA5A5A5A5@40 -> no mem_WE, no rsp_valid, FSM returns to IDLE. A read @40 after reset returns the old content.
- DMEM_ARB_STATS_EN: 3 p0 grants, 2 p1 grants, 1 contention cycle -> counters read 3/2/1; all counters read 0 after rst.
